// File: rtl/mips_loader_pkg.sv
// mips_loader_pkg: loader FSM states and byte-stream framing constants
package mips_loader_pkg;
    typedef enum logic [2:0] {IDLE, HDR, WORD, FILL, DONE, ERR} state_t;
    localparam int BYTES_PER_WORD = 4;
    localparam int HDR_BYTES = 2;
endpackage

// File: rtl/imem_stream_loader_if.sv
// imem_stream_loader_if: host byte link, valid/ready handshake
interface imem_stream_loader_if;
    logic [7:0] in_data;
    logic in_valid;
    logic in_ready;
    modport master (output in_data, in_valid, input in_ready);
    modport slave (input in_data, in_valid, output in_ready);
endinterface

// File: rtl/stream_word_packer.sv
// stream_word_packer: assembles MSB-first bytes into words, flags the completing byte
module stream_word_packer
    import mips_loader_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic take,
    input  logic [7:0] data,
    output logic word_valid,
    output logic [8*BYTES_PER_WORD-1:0] word
);
    localparam int CW = $clog2(BYTES_PER_WORD);
    logic [8*(BYTES_PER_WORD-1)-1:0] sr;
    logic [CW-1:0] cnt;
    assign word_valid = take && cnt == CW'(BYTES_PER_WORD - 1);
    assign word = {sr, data};
    // Shift accepted bytes in; a completed word wraps the counter, idle cycles keep partial bytes
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            sr <= '0;
            cnt <= '0;
        end else if (clr) begin
            sr <= '0;
            cnt <= '0;
        end else if (take) begin
            sr <= word[$bits(sr)-1:0];
            cnt <= cnt + CW'(1);
        end
endmodule

// File: rtl/imem_stream_loader.sv
// imem_stream_loader: streams a program into instruction memory, zero-fills the tail, releases the core
module imem_stream_loader
    import mips_loader_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    imem_stream_loader_if.slave link,
    output logic imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic core_rst,
    output logic busy,
    output logic done,
    output logic err,
    output logic [ADDR_W:0] words_loaded
);
    localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W+1)'(DEPTH);
    localparam logic [15:0] DEPTH_H = 16'(DEPTH);
    state_t state, state_n;
    logic rdy, rdy_n, hb, hb_n, we_n, core_rst_n, busy_n, done_n, err_n;
    logic [7:0] hi, hi_n;
    logic [15:0] hdr;
    logic [ADDR_W:0] cnt, cnt_n, nwords, nwords_n, wl_n;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] wdata_n;
    logic take, clr, word_valid;
    logic [31:0] word;
    assign link.in_ready = rdy;
    assign take = link.in_valid && rdy;
    assign hdr = {hi, link.in_data};
    assign clr = start && (state == IDLE || state == DONE || state == ERR);
    stream_word_packer packer (
        .clk(clk),
        .rst(rst),
        .clr(clr),
        .take(take && state == WORD),
        .data(link.in_data),
        .word_valid(word_valid),
        .word(word)
    );
    // Next state and next registered outputs; one counter serves as word index then fill address
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        nwords_n = nwords;
        hi_n = hi;
        hb_n = hb;
        we_n = 1'b0;
        addr_n = imem_addr;
        wdata_n = imem_wdata;
        core_rst_n = core_rst;
        busy_n = busy;
        done_n = done;
        err_n = err;
        wl_n = words_loaded;
        case (state)
            IDLE: if (start) begin
                state_n = HDR;
                busy_n = 1'b1;
            end
            HDR: if (take) begin
                hb_n = !hb;
                hi_n = link.in_data;
                if (hb) begin
                    cnt_n = '0;
                    nwords_n = hdr[ADDR_W:0];
                    err_n = hdr > DEPTH_H;
                    busy_n = !(hdr > DEPTH_H);
                    state_n = hdr > DEPTH_H ? ERR : hdr == 16'd0 ? FILL : WORD;
                end
            end
            WORD: if (word_valid) begin
                we_n = 1'b1;
                addr_n = cnt[ADDR_W-1:0];
                wdata_n = word;
                cnt_n = cnt + (ADDR_W+1)'(1);
                wl_n = words_loaded + (ADDR_W+1)'(1);
                state_n = cnt_n == nwords ? FILL : WORD;
            end
            FILL: if (cnt < DEPTH_A) begin
                we_n = 1'b1;
                addr_n = cnt[ADDR_W-1:0];
                wdata_n = '0;
                cnt_n = cnt + (ADDR_W+1)'(1);
            end else begin
                state_n = DONE;
                busy_n = 1'b0;
                done_n = 1'b1;
                core_rst_n = 1'b1;
            end
            DONE, ERR: if (start) begin
                state_n = HDR;
                hb_n = 1'b0;
                busy_n = 1'b1;
                core_rst_n = 1'b0;
                done_n = 1'b0;
                err_n = 1'b0;
                wl_n = '0;
            end
            default: state_n = IDLE;
        endcase
        rdy_n = state_n == HDR || state_n == WORD || state_n == ERR;
    end
    // Register state and every output so the memory and core see glitch-free signals
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= IDLE;
            rdy <= 1'b0;
            hb <= 1'b0;
            hi <= '0;
            cnt <= '0;
            nwords <= '0;
            imem_we <= 1'b0;
            imem_addr <= '0;
            imem_wdata <= '0;
            core_rst <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            err <= 1'b0;
            words_loaded <= '0;
        end else begin
            state <= state_n;
            rdy <= rdy_n;
            hb <= hb_n;
            hi <= hi_n;
            cnt <= cnt_n;
            nwords <= nwords_n;
            imem_we <= we_n;
            imem_addr <= addr_n;
            imem_wdata <= wdata_n;
            core_rst <= core_rst_n;
            busy <= busy_n;
            done <= done_n;
            err <= err_n;
            words_loaded <= wl_n;
        end
endmodule

// File: tb/tb_imem_stream_loader.sv
// tb_imem_stream_loader: directed load sessions with a write-capturing memory model
module tb_imem_stream_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic imem_we, core_rst, busy, done, err;
    logic [7:0] imem_addr;
    logic [31:0] imem_wdata;
    logic [8:0] words_loaded;
    int vecs = 0;
    int errs = 0;
    int sess = 0;
    int wr0 = 0;
    logic [31:0] exp_mem [256];

    always #5 clk = ~clk;

    imem_stream_loader_if link();

    imem_stream_loader dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .link(link),
        .imem_we(imem_we),
        .imem_addr(imem_addr),
        .imem_wdata(imem_wdata),
        .core_rst(core_rst),
        .busy(busy),
        .done(done),
        .err(err),
        .words_loaded(words_loaded)
    );

    logic [31:0] mem [256];
    int tag [256];
    int wr_cnt = 0;
    int cyc = 0;
    int last_we_cyc = 0;
    int done_cyc = 0;
    logic done_d = 1'b0;

    // Capture every memory write with the session that produced it
    always @(negedge clk) begin
        cyc <= cyc + 1;
        done_d <= done;
        if (imem_we) begin
            mem[imem_addr] <= imem_wdata;
            tag[imem_addr] <= sess;
            wr_cnt <= wr_cnt + 1;
            last_we_cyc <= cyc;
        end
        if (done && !done_d) done_cyc <= cyc;
    end

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k = 0;
        @(negedge clk);
        link.in_data = b;
        link.in_valid = 1'b1;
        while (!link.in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("accept_wait_expired", 64'(k >= 50), 64'd0);
        @(posedge clk);
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge clk);
            link.in_valid = 1'b0;
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int mid_gap);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[31-8*i -: 8]);
            if (i == 1 && mid_gap > 0) gap(mid_gap);
        end
    endtask

    task automatic send_hdr(input logic [15:0] h);
        send_byte(h[15:8]);
        send_byte(h[7:0]);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (!done && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("done_reached", 64'(done), 64'd1);
        @(negedge clk);
    endtask

    task automatic check_session(input string name, input int nwr, input logic [8:0] wl);
        int bad = 0;
        for (int a = 0; a < 256; a++)
            if (tag[a] != sess || mem[a] !== exp_mem[a]) bad++;
        check({name, "_bad_words"}, 64'(bad), 64'd0);
        check({name, "_write_count"}, 64'(wr_cnt - wr0), 64'(nwr));
        check({name, "_done_after_last_write"}, 64'(done_cyc - last_we_cyc), 64'd1);
        check({name, "_words_loaded"}, 64'(words_loaded), 64'(wl));
        check({name, "_core_rst_busy"}, {62'd0, core_rst, busy}, 64'b10);
    endtask

    function automatic logic [31:0] wgen(input int i);
        logic [7:0] b = 8'(i);
        return {b, ~b, b ^ 8'hA5, 8'h3C};
    endfunction

    initial begin
        link.in_data = 8'h00;
        link.in_valid = 1'b0;
        for (int a = 0; a < 256; a++) tag[a] = -1;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {imem_we, busy, done, err, core_rst, link.in_ready, words_loaded, imem_addr, imem_wdata}, 64'd0);
        rst = 1'b1;

        sess = 1;
        for (int a = 0; a < 256; a++) exp_mem[a] = 32'd0;
        exp_mem[0] = 32'h20080005;
        exp_mem[1] = 32'h01095020;
        wr0 = wr_cnt;
        pulse_start();
        check("s1_hdr_busy_ready", {62'd0, busy, link.in_ready}, 64'b11);
        send_hdr(16'h0002);
        send_word(32'h20080005, 0);
        send_word(32'h01095020, 0);
        @(negedge clk);
        link.in_valid = 1'b0;
        check("s1_write_after_4th_byte", {imem_we, imem_addr, imem_wdata}, {23'd0, 1'b1, 8'd1, 32'h01095020});
        check("s1_ready_low_in_fill", 64'(link.in_ready), 64'd0);
        wait_done();
        check_session("s1", 256, 9'd2);

        sess = 2;
        for (int a = 0; a < 256; a++) exp_mem[a] = 32'd0;
        wr0 = wr_cnt;
        pulse_start();
        check("s2_restart_core_rst_done", {62'd0, core_rst, done}, 64'd0);
        send_hdr(16'h0000);
        gap(1);
        wait_done();
        check_session("s2", 256, 9'd0);

        sess = 3;
        for (int a = 0; a < 256; a++) exp_mem[a] = wgen(a);
        wr0 = wr_cnt;
        pulse_start();
        send_hdr(16'h0100);
        for (int i = 0; i < 256; i++) begin
            if (i == 7 || i == 200) start = 1'b1;
            send_word(wgen(i), (i % 7 == 3) ? 2 : 0);
            start = 1'b0;
            if (i % 5 == 2) gap(1 + i % 3);
        end
        gap(1);
        wait_done();
        check_session("s3", 256, 9'h100);

        sess = 4;
        pulse_start();
        send_hdr(16'h0101);
        @(negedge clk);
        check("s4_err_state", {60'd0, err, core_rst, busy, link.in_ready}, 64'b1001);
        wr0 = wr_cnt;
        send_word(32'hFFFFFFFF, 0);
        gap(3);
        check("s4_no_write_in_err", 64'(wr_cnt - wr0), 64'd0);
        check("s4_err_held", 64'(err), 64'd1);

        sess = 5;
        for (int a = 0; a < 256; a++) exp_mem[a] = 32'd0;
        exp_mem[0] = 32'hAABBCCDD;
        wr0 = wr_cnt;
        pulse_start();
        check("s5_err_cleared", {62'd0, err, busy}, 64'b01);
        send_hdr(16'h0001);
        send_word(32'hAABBCCDD, 0);
        gap(1);
        wait_done();
        check_session("s5", 256, 9'd1);

        pulse_start();
        send_hdr(16'h0001);
        send_byte(8'hEE);
        send_byte(8'hEF);
        #2 rst = 1'b0;
        #1 check("async_reset_outputs", {imem_we, busy, done, err, core_rst, link.in_ready, words_loaded, imem_addr, imem_wdata}, 64'd0);
        @(negedge clk);
        link.in_valid = 1'b0;
        rst = 1'b1;
        sess = 6;
        for (int a = 0; a < 256; a++) exp_mem[a] = 32'd0;
        exp_mem[0] = 32'h11223344;
        wr0 = wr_cnt;
        pulse_start();
        send_hdr(16'h0001);
        send_word(32'h11223344, 1);
        gap(1);
        wait_done();
        check_session("s6", 256, 9'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/imem_stream_loader.md
Name: imem_stream_loader

Overview:
- Hardware counterpart of the bench-side instruction preload for pipelined_mips. It is the writer for the instruction-memory read port.
- Accepts a byte stream over valid/ready, assembles big-endian 32-bit instruction words, and writes them into instruction memory from address 0.
- Zero-fills the remaining addresses, then releases the core from reset.
- Sits between a host byte link (UART/JTAG bridge) and the instruction memory write port, and drives the core's reset.

Parameters:
- DEPTH, 256, instruction memory depth in words.
- ADDR_W, 8, instruction memory word-address width; must satisfy 2**ADDR_W >= DEPTH.
- DATA_W, 32, instruction word width; fixed at 32, 4 bytes per word.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse that begins a load session.
- in_data  in  8  stream byte.
- in_valid  in  1  byte valid.
- in_ready  out  1  loader can accept a byte.
- imem_we  out  1  instruction memory write enable.
- imem_addr  out  ADDR_W  word address.
- imem_wdata  out  32  write data.
- core_rst  out  1  active-low reset to pipelined_mips; 0 holds the core.
- busy  out  1  session in progress.
- done  out  1  load complete; core running.
- err  out  1  header count exceeded DEPTH.
- words_loaded  out  ADDR_W+1  number of words written from the stream.

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0, including core_rst=0 (core held); internal byte counter, header and word shift registers cleared.
- All outputs are registered. A byte is accepted when in_valid && in_ready.
- Stream format: 2-byte header N (word count), MSB first; then N words of 4 bytes each, MSB first (same word order as the hex preload file).
- IDLE: in_ready=0. On start go to HDR and set busy=1.
- HDR: in_ready=1; collect 2 bytes.
  - N > DEPTH -> ERR.
  - N == 0 -> FILL with fill address 0.
  - Otherwise -> WORD.
- WORD: in_ready=1; shift bytes into the word register.
  - The 4th byte is accepted in cycle t. In cycle t+1: imem_we=1, imem_addr=word index, imem_wdata=assembled word, words_loaded incremented.
  - The 4th byte may be accepted back-to-back with the next word's 1st byte; there are no bubbles on the input.
  - After word N-1 is written -> FILL.
- FILL: in_ready=0; one write per cycle, imem_wdata=0, addresses N..DEPTH-1.
  - N == DEPTH skips FILL entirely: DONE follows the last write.
- DONE: entered the cycle after the last write. imem_we=0, busy=0, done=1, core_rst=1. Held until reset or start.
- ERR: in_ready=1 (sink and discard bytes), err=1, busy=0, core_rst=0. Held until reset or start.
- start in DONE or ERR: restart. The next cycle sets core_rst=0, done=0, err=0, words_loaded=0, state HDR. Memory is not pre-cleared; FILL covers the unwritten tail.
- start in HDR, WORD or FILL is ignored.
- in_valid gaps (0) mid-word pause collection; partial bytes are retained indefinitely.
- Bytes presented in IDLE, FILL or DONE are not accepted (in_ready=0).
- Reset mid-session: immediate return to IDLE, core_rst=0. Memory contents are undefined for verification purposes.
- imem_addr wraps only via DEPTH bound checks and never exceeds DEPTH-1.

Decomposition:
- Shared package (mips_loader_pkg):
  - state enum IDLE/HDR/WORD/FILL/DONE/ERR;
  - BYTES_PER_WORD=4;
  - HDR_BYTES=2.
- One natural sub-module: stream_word_packer (byte-to-word shift register, byte counter, word_valid pulse), reusable for the data-memory preload path.
- The FSM and address counter stay in the top module.

Test Plan:
- Reset then start; header 0x0002; bytes 20 08 00 05, 01 09 50 20, streamed back-to-back.
  - Expect writes addr0=0x20080005, addr1=0x01095020.
  - Then 254 zero writes (addr2..255); done=1 and core_rst=1 exactly 1 cycle after the addr255 write; words_loaded=2.
- Header 0x0000 -> 256 zero writes starting at addr0, then done; words_loaded=0.
- Header 0x0100 (256 words), random in_valid gaps -> all 256 written with correct data; no FILL writes; done the cycle after the addr255 write.
- Header 0x0101 -> err=1, core_rst=0, subsequent bytes accepted with no imem_we. A start pulse clears err and reloads a 1-word program correctly.
- Assert rst low after the 2nd byte of a word -> all outputs 0 asynchronously, before the next edge. Restart loads cleanly with no stale partial bytes.
- From DONE, pulse start -> core_rst drops next cycle; new program written; start pulses issued during WORD have no effect.
